rf_safe_shutdown: RTL and testbench
===================================

RF_SAFE_SHUTDOWN -- requirements
Module: rf_safe_shutdown

Interface
REQ-001 Parameter GAIN_W, default 16: width of amplitude gain words.
REQ-002 Parameter RAMP_STEP, default 256: gain decrement/increment per ramp step.
REQ-003 Parameter RAMP_DIV, default 4: clock cycles per ramp step, legal range >= 1.
REQ-004 Parameter WARN_SHIFT, default 2: pre-attenuation shift applied while warning.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 wd_triggered  in  1  watchdog timeout flag, level.
REQ-008 wd_warning  in  1  watchdog warning flag, level.
REQ-009 rearm  in  1  host re-arm request, single-cycle pulse.
REQ-010 gain_in  in  GAIN_W  requested carrier amplitude gain, unsigned.
REQ-011 gain_out  out  GAIN_W  gain to modulator, registered.
REQ-012 rf_enable  out  1  RF output stage enable, registered.
REQ-013 fault_latched  out  1  sticky flag: shutdown occurred since last re-arm.
REQ-014 state  out  2  FSM state code: RUN=0, RAMP_DOWN=1, MUTED=2, RAMP_UP=3.
REQ-015 shutdown_count  out  8  saturating count of RAMP_DOWN entries.

Function
REQ-016 RUN, wd_warning=0: gain_out SHALL equal gain_in of previous cycle (1-cycle latency); rf_enable=1.
REQ-017 RUN, wd_warning=1, wd_triggered=0: gain_out SHALL equal gain_in - (gain_in >> WARN_SHIFT).
REQ-018 RUN, wd_triggered=1: next state RAMP_DOWN; internal level loaded with current gain_out; fault_latched set; shutdown_count += 1, saturating at 255.
REQ-019 RAMP_DOWN: step timer counts 0..RAMP_DIV-1; on terminal count, level = level - RAMP_STEP, saturating at 0; gain_out = level.
REQ-020 RAMP_DOWN, level == 0: next state MUTED; rf_enable deasserts on the MUTED-entry edge, never before gain_out is 0.
REQ-021 RAMP_DOWN SHALL NOT abort when wd_triggered falls; rearm is ignored in RAMP_DOWN.
REQ-022 MUTED: gain_out=0, rf_enable=0; exit only on rearm=1 with wd_triggered=0 in the same cycle; rearm with wd_triggered=1 is ignored.
REQ-023 MUTED exit SHALL clear fault_latched and the step timer.
REQ-024 RAMP_UP: rf_enable=1; on each step-timer terminal count, level = min(level + RAMP_STEP, gain_in), with no overflow past 2^GAIN_W-1; level reaching gain_in -> RUN.
REQ-025 RAMP_UP, wd_triggered=1: immediate transition to RAMP_DOWN from current level, with REQ-018 side effects applied.
REQ-026 RAMP_UP, gain_in falls below level: level clamps to gain_in on the next cycle and the FSM transitions to RUN.
REQ-027 rearm in RUN or RAMP_UP: no effect.

Reset
REQ-028 On rst: state=RUN, gain_out=0, rf_enable=0, fault_latched=0, shutdown_count=0, level=0, step timer=0.
REQ-029 First cycle after reset release: rf_enable=1, gain_out follows REQ-016 from the next edge.
REQ-030 Reset mid-ramp SHALL abandon the ramp with no residual state.

Configuration
REQ-031 Macro RF_SAFE_SOFT_RAMP_UP_EN defined: MUTED exit goes to RAMP_UP per REQ-024..026.
REQ-032 Macro undefined: MUTED exit goes directly to RUN; gain_out = gain_in on the following edge; RAMP_UP encoding is unreachable.

Structure
REQ-033 Shared package rf_safe_pkg SHALL hold the state encoding constants and default RAMP_STEP/RAMP_DIV values.
REQ-034 Sub-module rf_ramp_gen (step timer plus saturating level up/down) SHALL be instantiated once.

Verification
REQ-035 gain_in=0x1000, warning=0 -> gain_out=0x1000 one cycle later, rf_enable=1.
REQ-036 RUN, gain_in=0x1000, warning=1 -> gain_out=0x0C00.
REQ-037 gain_out=0x1000, trigger pulse -> gain_out decrements by 0x100 every 4 cycles; MUTED after 64 cycles; rf_enable=0; count=1.
REQ-038 MUTED, rearm with trigger=1 -> stays MUTED; rearm with trigger=0 -> fault_latched=0, ramps to 0x1000 (or RUN next edge without macro).
REQ-039 RAMP_UP at level 0x0800, trigger -> RAMP_DOWN from 0x0800; count increments.
REQ-040 256 trigger/rearm cycles -> shutdown_count holds 255; async rst mid-RAMP_DOWN -> all outputs at reset values.

Source files
------------

// File: rtl/rf_safe_pkg.sv
// Shared types for the RF safe-shutdown block: FSM state encoding, ramp
// generator modes and default ramp parameters.
package rf_safe_pkg;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_RAMP_DOWN = 2'd1,
    ST_MUTED     = 2'd2,
    ST_RAMP_UP   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    RG_HOLD = 2'd0,
    RG_LOAD = 2'd1,
    RG_DOWN = 2'd2,
    RG_UP   = 2'd3
  } ramp_mode_t;

  localparam int DEF_GAIN_W     = 16;
  localparam int DEF_RAMP_STEP  = 256;
  localparam int DEF_RAMP_DIV   = 4;
  localparam int DEF_WARN_SHIFT = 2;

endpackage

// File: rtl/rf_safe_shutdown_if.sv
// Watchdog/host inputs and gain/status outputs of rf_safe_shutdown.
// master drives the watchdog flags and requested gain; slave is the shutdown block.
interface rf_safe_shutdown_if #(
  parameter int GAIN_W = rf_safe_pkg::DEF_GAIN_W
);
  logic              wd_triggered;
  logic              wd_warning;
  logic              rearm;
  logic [GAIN_W-1:0] gain_in;
  logic [GAIN_W-1:0] gain_out;
  logic              rf_enable;
  logic              fault_latched;
  logic [1:0]        state;
  logic [7:0]        shutdown_count;

  modport master (
    output wd_triggered, wd_warning, rearm, gain_in,
    input  gain_out, rf_enable, fault_latched, state, shutdown_count
  );

  modport slave (
    input  wd_triggered, wd_warning, rearm, gain_in,
    output gain_out, rf_enable, fault_latched, state, shutdown_count
  );
endinterface

// File: rtl/rf_ramp_gen.sv
// Step timer plus saturating gain level that ramps down to 0 or up to a limit.
// Latency: level updates on the clock edge after each RAMP_DIV-cycle timer terminal count.
// Backpressure: none; mode is sampled every cycle.
module rf_ramp_gen
  import rf_safe_pkg::*;
#(
  parameter int GAIN_W    = DEF_GAIN_W,
  parameter int RAMP_STEP = DEF_RAMP_STEP,
  parameter int RAMP_DIV  = DEF_RAMP_DIV
) (
  input  logic              clk,
  input  logic              rst,
  input  ramp_mode_t        mode,
  input  logic [GAIN_W-1:0] load_val,
  input  logic [GAIN_W-1:0] limit,
  output logic [GAIN_W-1:0] level,
  output logic [GAIN_W-1:0] level_nxt
);

  localparam int              TW   = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [TW-1:0]   TERM = TW'(RAMP_DIV - 1);
  localparam logic [GAIN_W:0] STEP = (GAIN_W + 1)'(RAMP_STEP);

  logic [TW-1:0]   timer;
  logic [TW-1:0]   timer_nxt;
  logic            tick;
  logic [GAIN_W:0] up_sum;

  assign tick   = (timer == TERM);
  // one extra bit so the upward step can never wrap past full scale
  assign up_sum = {1'b0, level} + STEP;

  always_comb begin
    timer_nxt = '0;
    level_nxt = level;
    unique case (mode)
      RG_LOAD: level_nxt = load_val;
      RG_DOWN: begin
        timer_nxt = tick ? '0 : timer + 1'b1;
        if (tick) begin
          if ({1'b0, level} <= STEP) level_nxt = '0;
          else                       level_nxt = level - STEP[GAIN_W-1:0];
        end
      end
      RG_UP: begin
        timer_nxt = tick ? '0 : timer + 1'b1;
        if (tick) begin
          if (up_sum >= {1'b0, limit}) level_nxt = limit;
          else                         level_nxt = up_sum[GAIN_W-1:0];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer <= '0;
      level <= '0;
    end else begin
      timer <= timer_nxt;
      level <= level_nxt;
    end
  end

endmodule

// File: rtl/rf_safe_shutdown.sv
// Watchdog-driven RF shutdown: attenuates on warning, ramps gain to 0 then mutes on timeout; RF_SAFE_SOFT_RAMP_UP_EN adds a soft ramp-up after re-arm.
// Latency: gain_out, rf_enable and status are registered, one cycle behind the inputs.
// Backpressure: none; level-sensitive watchdog flags and a single-cycle rearm pulse.
module rf_safe_shutdown
  import rf_safe_pkg::*;
#(
  parameter int GAIN_W     = DEF_GAIN_W,
  parameter int RAMP_STEP  = DEF_RAMP_STEP,
  parameter int RAMP_DIV   = DEF_RAMP_DIV,
  parameter int WARN_SHIFT = DEF_WARN_SHIFT
) (
  input logic               clk,
  input logic               rst,
  rf_safe_shutdown_if.slave bus
);

  state_t            state_q, state_d;
  logic [GAIN_W-1:0] gain_q, gain_d;
  logic              rf_en_q, rf_en_d;
  logic              fault_q, fault_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              enter_down;
  ramp_mode_t        ramp_mode;
  logic [GAIN_W-1:0] load_val;
  logic [GAIN_W-1:0] level;
  logic [GAIN_W-1:0] level_nxt;

  rf_ramp_gen #(
    .GAIN_W    (GAIN_W),
    .RAMP_STEP (RAMP_STEP),
    .RAMP_DIV  (RAMP_DIV)
  ) u_ramp (
    .clk       (clk),
    .rst       (rst),
    .mode      (ramp_mode),
    .load_val  (load_val),
    .limit     (bus.gain_in),
    .level     (level),
    .level_nxt (level_nxt)
  );

  always_comb begin
    state_d    = state_q;
    gain_d     = gain_q;
    rf_en_d    = rf_en_q;
    fault_d    = fault_q;
    cnt_d      = cnt_q;
    enter_down = 1'b0;
    ramp_mode  = RG_HOLD;
    load_val   = gain_q;
    unique case (state_q)
      ST_RUN: begin
        rf_en_d = 1'b1;
        if (bus.wd_triggered)    enter_down = 1'b1;
        else if (bus.wd_warning) gain_d = bus.gain_in - (bus.gain_in >> WARN_SHIFT);
        else                     gain_d = bus.gain_in;
      end
      ST_RAMP_DOWN: begin
        ramp_mode = RG_DOWN;
        gain_d    = level_nxt;
        // gain_out already reads 0 here, so dropping the enable is glitch-free
        if (level == '0) begin
          state_d = ST_MUTED;
          rf_en_d = 1'b0;
        end else begin
          rf_en_d = 1'b1;
        end
      end
      ST_MUTED: begin
        gain_d  = '0;
        rf_en_d = 1'b0;
        if (bus.rearm && !bus.wd_triggered) begin
          fault_d = 1'b0;
`ifdef RF_SAFE_SOFT_RAMP_UP_EN
          state_d = ST_RAMP_UP;
`else
          state_d = ST_RUN;
`endif
        end
      end
      ST_RAMP_UP: begin
`ifdef RF_SAFE_SOFT_RAMP_UP_EN
        rf_en_d = 1'b1;
        if (bus.wd_triggered) begin
          enter_down = 1'b1;
          load_val   = level;
          gain_d     = level;
        end else if (level >= bus.gain_in) begin
          // covers both reaching the target and the target dropping below us
          state_d   = ST_RUN;
          ramp_mode = RG_LOAD;
          load_val  = bus.gain_in;
          gain_d    = bus.gain_in;
        end else begin
          ramp_mode = RG_UP;
          gain_d    = level_nxt;
        end
`else
        state_d = ST_RUN;
`endif
      end
      default: state_d = ST_RUN;
    endcase

    if (enter_down) begin
      state_d   = ST_RAMP_DOWN;
      ramp_mode = RG_LOAD;
      fault_d   = 1'b1;
      if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      gain_q  <= '0;
      rf_en_q <= 1'b0;
      fault_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gain_q  <= gain_d;
      rf_en_q <= rf_en_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.gain_out       = gain_q;
  assign bus.rf_enable      = rf_en_q;
  assign bus.fault_latched  = fault_q;
  assign bus.state          = state_q;
  assign bus.shutdown_count = cnt_q;

endmodule

// File: tb/tb_rf_safe_shutdown.sv
// Randomized self-checking bench for rf_safe_shutdown; expected gains come from
// closed-form ramp arithmetic (step count = elapsed cycles / RAMP_DIV).
module tb_rf_safe_shutdown;
  localparam int GW   = 16;
  localparam int STEP = 256;
  localparam int DIV  = 4;
  localparam int WSH  = 2;
  localparam int S_RUN = 0, S_DOWN = 1, S_MUTED = 2, S_UP = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   exp_cnt = 0;

  always #5 clk = ~clk;

  rf_safe_shutdown_if #(.GAIN_W(GW)) bus ();

  rf_safe_shutdown #(
    .GAIN_W(GW), .RAMP_STEP(STEP), .RAMP_DIV(DIV), .WARN_SHIFT(WSH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [27:0] obs();
    return {bus.state, bus.rf_enable, bus.fault_latched, bus.shutdown_count, bus.gain_out};
  endfunction

  function automatic logic [27:0] ex(int st, int rf, int fl, int cnt, int g);
    return {st[1:0], rf[0], fl[0], cnt[7:0], g[15:0]};
  endfunction

  function automatic int exp_down(int lvl, int k);
    int v = lvl - STEP * (k / DIV);
    return (v < 0) ? 0 : v;
  endfunction

  function automatic int exp_up(int tgt, int k);
    int v = STEP * (k / DIV);
    return (v > tgt) ? tgt : v;
  endfunction

  function automatic int edges_to(int lvl);
    return ((lvl + STEP - 1) / STEP) * DIV;
  endfunction

  function automatic int sat_inc(int c);
    return (c < 255) ? c + 1 : 255;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(int trig, int warn, int rearm, int g);
    bus.wd_triggered = trig[0];
    bus.wd_warning   = warn[0];
    bus.rearm        = rearm[0];
    bus.gain_in      = g[15:0];
  endtask

  task automatic wait_state(int st, int budget, string name);
    int n = 0;
    while (bus.state !== st[1:0] && n < budget) begin
      tick();
      n++;
    end
    n_tests++;
    if (bus.state !== st[1:0]) begin
      n_fail++;
      $display("FAIL %s: state %0d after %0d cycles, want %0d", name, bus.state, budget, st);
    end
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0);
    #3;
    n_tests++;
    if (obs() !== ex(S_RUN, 0, 0, 0, 0)) begin
      n_fail++;
      $display("FAIL reset_values: got %h want %h", obs(), ex(S_RUN, 0, 0, 0, 0));
    end
    tick();
    rst = 1'b0;
    drive(0, 0, 0, 16'h1000);
    tick();
    n_tests++;
    if (bus.rf_enable !== 1'b1 || bus.state !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_release: rf=%b st=%0d want rf=1 st=0", bus.rf_enable, bus.state);
    end
    tick();
    n_tests++;
    if (obs() !== ex(S_RUN, 1, 0, 0, 16'h1000)) begin
      n_fail++;
      $display("FAIL run_pass_0x1000: got %h want %h", obs(), ex(S_RUN, 1, 0, 0, 16'h1000));
    end
  endtask

  task automatic test_run_random();
    int g, w, want;
    for (int i = 0; i < 40; i++) begin
      g = (i == 0) ? 16'h1000 : int'($urandom_range(0, 16'hFFFF));
      w = (i == 0) ? 1 : int'($urandom_range(0, 1));
      drive(0, w, int'($urandom_range(0, 1)), g);
      want = w ? g - g / (2 ** WSH) : g;
      tick();
      n_tests++;
      if (obs() !== ex(S_RUN, 1, 0, exp_cnt, want)) begin
        n_fail++;
        $display("FAIL run_random i=%0d g=%h w=%0d: got %h want %h", i, g, w, obs(),
                 ex(S_RUN, 1, 0, exp_cnt, want));
      end
    end
  endtask

  task automatic test_ramp_down(int lvl);
    int t_end;
    t_end = edges_to(lvl);
    drive(0, 0, 0, lvl);
    tick();
    drive(1, 0, 0, int'($urandom_range(0, 16'hFFFF)));
    tick();
    exp_cnt = sat_inc(exp_cnt);
    n_tests++;
    if (obs() !== ex(S_DOWN, 1, 1, exp_cnt, lvl)) begin
      n_fail++;
      $display("FAIL ramp_down_entry L=%h: got %h want %h", lvl, obs(), ex(S_DOWN, 1, 1, exp_cnt, lvl));
    end
    for (int k = 1; k <= t_end + 1; k++) begin
      drive(int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
            int'($urandom_range(0, 16'hFFFF)));
      tick();
      n_tests++;
      if (obs() !== ex((k <= t_end) ? S_DOWN : S_MUTED, (k <= t_end) ? 1 : 0, 1, exp_cnt,
                       exp_down(lvl, k))) begin
        n_fail++;
        $display("FAIL ramp_down L=%h k=%0d: got %h want %h", lvl, k, obs(),
                 ex((k <= t_end) ? S_DOWN : S_MUTED, (k <= t_end) ? 1 : 0, 1, exp_cnt, exp_down(lvl, k)));
      end
    end
    drive(0, 0, 0, 0);
  endtask

  task automatic test_mute_rearm(int tgt);
    int r_end, st0;
    drive(1, 0, 1, tgt);
    tick();
    drive(0, 0, 0, tgt);
    tick();
    n_tests++;
    if (obs() !== ex(S_MUTED, 0, 1, exp_cnt, 0)) begin
      n_fail++;
      $display("FAIL rearm_while_trig: got %h want %h", obs(), ex(S_MUTED, 0, 1, exp_cnt, 0));
    end
    drive(0, 0, 1, tgt);
    tick();
    drive(0, 0, 0, tgt);
`ifdef RF_SAFE_SOFT_RAMP_UP_EN
    st0 = S_UP;
`else
    st0 = S_RUN;
`endif
    n_tests++;
    if (obs() !== ex(st0, 0, 0, exp_cnt, 0)) begin
      n_fail++;
      $display("FAIL rearm_exit: got %h want %h", obs(), ex(st0, 0, 0, exp_cnt, 0));
    end
`ifdef RF_SAFE_SOFT_RAMP_UP_EN
    r_end = edges_to(tgt);
    for (int k = 1; k <= r_end + 1; k++) begin
      tick();
      n_tests++;
      if (obs() !== ex((k <= r_end) ? S_UP : S_RUN, 1, 0, exp_cnt, exp_up(tgt, k))) begin
        n_fail++;
        $display("FAIL ramp_up T=%h k=%0d: got %h want %h", tgt, k, obs(),
                 ex((k <= r_end) ? S_UP : S_RUN, 1, 0, exp_cnt, exp_up(tgt, k)));
      end
    end
`else
    r_end = 0;
    tick();
    n_tests++;
    if (obs() !== ex(S_RUN, 1, 0, exp_cnt, tgt)) begin
      n_fail++;
      $display("FAIL rearm_direct_run: got %h want %h", obs(), ex(S_RUN, 1, 0, exp_cnt, tgt));
    end
`endif
  endtask

  // Trigger while gain_out sits at 0x0800: from RAMP_UP with the soft ramp, from RUN otherwise.
  task automatic test_rampup_trigger();
    int n, st_pre;
    drive(0, 0, 0, 0);
    tick();
    drive(1, 0, 0, 0);
    tick();
    exp_cnt = sat_inc(exp_cnt);
    drive(0, 0, 0, 0);
    wait_state(S_MUTED, 8, "mute_before_rampup");
`ifdef RF_SAFE_SOFT_RAMP_UP_EN
    drive(0, 0, 1, 16'h1000);
    st_pre = S_UP;
`else
    drive(0, 0, 1, 16'h0800);
    st_pre = S_RUN;
`endif
    tick();
    bus.rearm = 1'b0;
    n = 0;
    while (bus.gain_out !== 16'h0800 && n < 200) begin
      tick();
      n++;
    end
    n_tests++;
    if (obs() !== ex(st_pre, 1, 0, exp_cnt, 16'h0800)) begin
      n_fail++;
      $display("FAIL reach_0x0800: got %h want %h", obs(), ex(st_pre, 1, 0, exp_cnt, 16'h0800));
    end
    bus.wd_triggered = 1'b1;
    tick();
    bus.wd_triggered = 1'b0;
    exp_cnt = sat_inc(exp_cnt);
    n_tests++;
    if (obs() !== ex(S_DOWN, 1, 1, exp_cnt, 16'h0800)) begin
      n_fail++;
      $display("FAIL trigger_at_0x0800: got %h want %h", obs(), ex(S_DOWN, 1, 1, exp_cnt, 16'h0800));
    end
    wait_state(S_MUTED, edges_to(16'h0800) + 4, "mute_after_0x0800");
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 256; i++) begin
      drive(0, 0, 0, 0);
      tick();
      drive(1, 0, 0, 0);
      tick();
      exp_cnt = sat_inc(exp_cnt);
      drive(0, 0, 0, 0);
      wait_state(S_MUTED, 8, "sat_mute");
      drive(0, 0, 1, 0);
      tick();
      bus.rearm = 1'b0;
      wait_state(S_RUN, 8, "sat_run");
    end
    n_tests++;
    if (bus.shutdown_count !== exp_cnt[7:0] || exp_cnt != 255) begin
      n_fail++;
      $display("FAIL count_saturate: got %0d want 255", bus.shutdown_count);
    end
  endtask

  task automatic test_reset_mid_ramp();
    int lvl = 16'h0A00;
    drive(0, 0, 0, 16'h1000);
    tick();
    drive(1, 0, 0, 16'h1000);
    tick();
    drive(0, 0, 0, 16'h1000);
    repeat (21) tick();
    #2 rst = 1'b1;
    #1;
    exp_cnt = 0;
    n_tests++;
    if (obs() !== ex(S_RUN, 0, 0, 0, 0)) begin
      n_fail++;
      $display("FAIL async_reset_mid_ramp: got %h want %h", obs(), ex(S_RUN, 0, 0, 0, 0));
    end
    tick();
    rst = 1'b0;
    tick();
    tick();
    drive(0, 0, 0, lvl);
    tick();
    n_tests++;
    if (obs() !== ex(S_RUN, 1, 0, 0, lvl)) begin
      n_fail++;
      $display("FAIL post_reset_run: got %h want %h", obs(), ex(S_RUN, 1, 0, 0, lvl));
    end
    drive(1, 0, 0, lvl);
    tick();
    drive(0, 0, 0, lvl);
    for (int k = 1; k <= DIV; k++) begin
      tick();
      n_tests++;
      if (obs() !== ex(S_DOWN, 1, 1, 1, exp_down(lvl, k))) begin
        n_fail++;
        $display("FAIL post_reset_ramp k=%0d: got %h want %h", k, obs(), ex(S_DOWN, 1, 1, 1, exp_down(lvl, k)));
      end
    end
  endtask

  initial begin
    test_reset();
    test_run_random();
    test_ramp_down(16'h1000);
    test_mute_rearm(16'h1000);
    test_ramp_down(int'($urandom_range(1, 16'hFFFF)));
    test_mute_rearm(int'($urandom_range(0, 16'hFFFF)));
    test_ramp_down(0);
    test_mute_rearm(16'h0150);
    test_ramp_down(16'h0150);
    test_mute_rearm(16'hFFFF);
    test_rampup_trigger();
    drive(0, 0, 1, 0);
    tick();
    bus.rearm = 1'b0;
    wait_state(S_RUN, 8, "run_before_saturate");
    test_saturate();
    test_reset_mid_ramp();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
